// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_pkg;
  localparam int DATA_W     = 32;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;
endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive denied DMA cycles; raises force_o once the
// DMA has waited MAX_WAIT cycles so the next slot goes to the DMA.
module dmem_starve_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic force_o
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) cnt_d = '0;
    else if (cnt_q != MAX_C)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_o = dma_req_i && (cnt_q == MAX_C);
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority, a starved DMA gets
// a forced one-cycle slot, and read data is routed back to the issuing port.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic   cpu_gnt;
  logic   force_dma;
  owner_e rd_owner_q, rd_owner_d;
  logic   cpu_rvalid_q, dma_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  // Byte-offset and high address bits are dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dma_addr[31:ADDR_W+2], dma_addr[1:0]};

  dmem_starve_cnt #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .dma_req_i(dma_req),
    .dma_gnt_i(dma_gnt),
    .force_o  (force_dma)
  );

  always_comb begin
    cpu_gnt    = !rst && cpu_req && !force_dma;
    dma_gnt    = !rst && dma_req && (!cpu_req || force_dma);
    cpu_stall  = !rst && cpu_req && !cpu_gnt;
    mem_en     = cpu_gnt || dma_gnt;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rd_owner_d = OWN_NONE;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
      if (!cpu_we) rd_owner_d = OWN_CPU;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr[ADDR_W+1:2];
      mem_wdata = dma_wdata;
      if (!dma_we) rd_owner_d = OWN_DMA;
    end
  end

  // rd_owner_q tracks the read the memory is answering this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_q   <= OWN_NONE;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      cpu_rvalid_q <= (rd_owner_q == OWN_CPU);
      dma_rvalid_q <= (rd_owner_q == OWN_DMA);
      if (rd_owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (rd_owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
endmodule
